ball_tracker: RTL and testbench
===============================

BALL_TRACKER -- requirements
Module: ball_tracker

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- width  in  8  field width W from the command decoder
- width_valid  in  1  level; width is valid
- length  in  8  field length L
- length_valid  in  1  level; length is valid
- red  in  1  local colour is red
- blue  in  1  local colour is blue
- color_valid  in  1  level; red/blue are valid
- opponent_game_start  in  1  1-cycle pulse; opponent turn begins
- me_game_start  in  1  1-cycle pulse; local turn begins
- new_en_mov  in  1  1-cycle pulse; RxD_data_Opponent holds an opponent move
- RxD_data_Opponent  in  8  ASCII move byte
- my_move_valid  in  1  1-cycle pulse; local move request
- my_move  in  3  local direction code
- ball_x  out  8  ball column, 0..W
- ball_y  out  8  ball row, 0..L
- move_accepted  out  1  1-cycle pulse
- move_illegal  out  1  1-cycle pulse
- cfg_error  out  1  level; configuration rejected
- my_turn  out  1  level; local side to move
- goal_red  out  1  level; red scored
- goal_blue  out  1  level; blue scored
- game_over  out  1  level

Function
REQ-002 Direction codes SHALL be: 0=N(dy-1), 1=NE, 2=E(dx+1), 3=SE, 4=S(dy+1), 5=SW, 6=W, 7=NW. The ASCII bytes 0x30..0x37 map to codes 0..7.
REQ-003 The FSM states SHALL be IDLE, READY, OPP_TURN, MY_TURN and GAME_OVER.
REQ-004 In IDLE, when width_valid, length_valid and color_valid are all high in the same cycle, the block SHALL check the configuration:
- W and L even and each in 4..64 -> latch W, L and colour; set ball = (W/2, L/2); go to READY next cycle.
- otherwise -> set cfg_error=1 and stay in IDLE until rst.
REQ-005 READY SHALL go to OPP_TURN on opponent_game_start, else to MY_TURN when the latched colour is red.
REQ-006 OPP_TURN SHALL go to MY_TURN on me_game_start. MY_TURN SHALL go to OPP_TURN on opponent_game_start. my_turn=1 only in MY_TURN.
REQ-007 In OPP_TURN, new_en_mov SHALL be evaluated. In MY_TURN, my_move_valid SHALL be evaluated. A move input outside its state SHALL be ignored: no pulse, no update.
REQ-008 Move evaluation SHALL use 9-bit signed nx=x+dx, ny=y+dy. The move is illegal if nx<0, nx>W, ny<0 or ny>L, or if the opponent byte is not in 0x30..0x37.
REQ-009 Latency: one cycle after a legal move, the block SHALL update ball_x/ball_y and pulse move_accepted. One cycle after an illegal move, it SHALL pulse move_illegal and leave the ball unchanged. move_accepted and move_illegal SHALL never be high together.
REQ-010 Goal mouth SHALL be columns W/2-1..W/2+1. Red defends row 0.
- Accepted move to ny=0 inside the mouth -> goal_blue=1.
- Accepted move to ny=L inside the mouth -> goal_red=1.
- In both cases: game_over=1, state GAME_OVER, in the same cycle as move_accepted.
- ny=0 or ny=L outside the mouth is a legal edge point.
REQ-011 GAME_OVER SHALL ignore all inputs except rst.
REQ-012 If a turn-start pulse and a move pulse arrive in the same cycle, the move SHALL be evaluated against the current state, then the transition SHALL be taken.

Reset
REQ-013 On rst the block SHALL set: state=IDLE; ball_x=ball_y=0; all pulse outputs 0; cfg_error, my_turn, goal_red, goal_blue, game_over = 0; latched W/L/colour = 0.
REQ-014 rst mid-move SHALL discard the pending move, with no pulse in the following cycle.

Structure
REQ-015 A shared package ball_pkg SHALL hold: the direction codes, the ASCII base 0x30, the state enum, the W/L min/max limits, and the mouth half-width 1.
REQ-016 A combinational sub-module move_decoder SHALL map a byte or code to signed dx, dy and a valid flag. One instance SHALL be used per move source.

Verification
REQ-017 W=8, L=10, red -> READY -> MY_TURN; ball=(4,5); my_turn=1.
REQ-018 W=7, L=10 -> cfg_error=1; state stays IDLE; move inputs are ignored.
REQ-019 OPP_TURN, ball (4,5), byte 0x32 -> one cycle later ball=(5,5), move_accepted pulse. Byte 0x41 -> move_illegal, ball unchanged.
REQ-020 Ball (0,3), my_move=6 -> move_illegal, ball stays (0,3). Ball (8,3), my_move=2 -> move_illegal.
REQ-021 Ball (4,1), my_move=0 -> ball (4,0), goal_blue=1, game_over=1. Further moves ignored until rst.
REQ-022 Ball (1,1), move 7 -> (0,0) accepted, no goal. rst asserted together with my_move_valid -> no pulse; all outputs at reset values.

Source files
------------

// File: rtl/ball_pkg.sv
// ball_pkg: shared definitions for the ball tracker.
//   - direction codes 0..7 (N, NE, E, SE, S, SW, W, NW)
//   - ASCII base for opponent move bytes ('0' .. '7')
//   - tracker FSM state and latched colour encodings
//   - field dimension limits and goal mouth half-width
//   - dim_ok(): checks one field dimension for even and in range
package ball_pkg;

   typedef enum logic [2:0] {IDLE, READY, OPP_TURN, MY_TURN, GAME_OVER} state_t;
   typedef enum logic [1:0] {COL_NONE, COL_RED, COL_BLUE} colour_t;

   localparam logic [2:0] DIR_N  = 3'd0;
   localparam logic [2:0] DIR_NE = 3'd1;
   localparam logic [2:0] DIR_E  = 3'd2;
   localparam logic [2:0] DIR_SE = 3'd3;
   localparam logic [2:0] DIR_S  = 3'd4;
   localparam logic [2:0] DIR_SW = 3'd5;
   localparam logic [2:0] DIR_W  = 3'd6;
   localparam logic [2:0] DIR_NW = 3'd7;

   localparam logic [7:0] ASCII_BASE = 8'h30;
   localparam logic [7:0] DIM_MIN    = 8'd4;
   localparam logic [7:0] DIM_MAX    = 8'd64;
   localparam logic [7:0] MOUTH_HALF = 8'd1;

   function automatic logic dim_ok(input logic [7:0] d);
      return !d[0] && (d >= DIM_MIN) && (d <= DIM_MAX);
   endfunction

endpackage

// File: rtl/move_decoder.sv
// move_decoder: maps a move byte to a signed unit step.
//   code_byte  in   move byte; ASCII '0'..'7' when ASCII=1, raw code 0..7 otherwise
//   dx, dy     out  signed step in -1..+1 (dy negative is north)
//   valid      out  byte is a recognised move
module move_decoder import ball_pkg::*; #(
   parameter bit ASCII = 1'b1
) (
   input  logic              [7:0] code_byte,
   output logic signed       [1:0] dx,
   output logic signed       [1:0] dy,
   output logic                    valid
);

   logic [2:0] dir;

   always_comb begin
      dir = code_byte[2:0];
      // '0'..'7' share the upper five bits of the ASCII base; raw codes must have them clear
      valid = ASCII ? (code_byte[7:3] == ASCII_BASE[7:3]) : (code_byte[7:3] == 5'd0);
      dx = 2'sb00;
      dy = 2'sb00;
      case (dir)
         DIR_N:  begin dx = 2'sb00; dy = 2'sb11; end
         DIR_NE: begin dx = 2'sb01; dy = 2'sb11; end
         DIR_E:  begin dx = 2'sb01; dy = 2'sb00; end
         DIR_SE: begin dx = 2'sb01; dy = 2'sb01; end
         DIR_S:  begin dx = 2'sb00; dy = 2'sb01; end
         DIR_SW: begin dx = 2'sb11; dy = 2'sb01; end
         DIR_W:  begin dx = 2'sb11; dy = 2'sb00; end
         DIR_NW: begin dx = 2'sb11; dy = 2'sb11; end
         default: begin dx = 2'sb00; dy = 2'sb00; end
      endcase
   end

endmodule

// File: rtl/ball_tracker.sv
// ball_tracker: tracks the ball position of a paper-soccer style game.
//   clk, rst                 clock, synchronous active-high reset
//   width/length(+_valid)    field size from the command decoder
//   red/blue/color_valid     local colour
//   opponent_game_start      pulse; opponent's turn begins
//   me_game_start            pulse; local turn begins
//   new_en_mov, RxD_data_Opponent   opponent move (ASCII '0'..'7')
//   my_move_valid, my_move   local move (code 0..7)
//   ball_x, ball_y           ball position
//   move_accepted/illegal    1-cycle result pulses, one cycle after the move
//   cfg_error, my_turn, goal_red, goal_blue, game_over   status levels
module ball_tracker import ball_pkg::*; (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] width,
   input  logic       width_valid,
   input  logic [7:0] length,
   input  logic       length_valid,
   input  logic       red,
   input  logic       blue,
   input  logic       color_valid,
   input  logic       opponent_game_start,
   input  logic       me_game_start,
   input  logic       new_en_mov,
   input  logic [7:0] RxD_data_Opponent,
   input  logic       my_move_valid,
   input  logic [2:0] my_move,
   output logic [7:0] ball_x,
   output logic [7:0] ball_y,
   output logic       move_accepted,
   output logic       move_illegal,
   output logic       cfg_error,
   output logic       my_turn,
   output logic       goal_red,
   output logic       goal_blue,
   output logic       game_over
);

   state_t     state;
   colour_t    colour_q;
   logic [7:0] w_q;
   logic [7:0] l_q;

   logic signed [1:0] opp_dx, opp_dy, my_dx, my_dy;
   logic              opp_ok, my_ok;

   move_decoder #(.ASCII(1'b1)) u_opp_dec (
      .code_byte (RxD_data_Opponent),
      .dx        (opp_dx),
      .dy        (opp_dy),
      .valid     (opp_ok)
   );

   move_decoder #(.ASCII(1'b0)) u_my_dec (
      .code_byte ({5'd0, my_move}),
      .dx        (my_dx),
      .dy        (my_dy),
      .valid     (my_ok)
   );

   logic              mv_req, mv_fmt_ok, mv_legal, in_mouth, mv_goal_red, mv_goal_blue;
   logic signed [8:0] nx, ny;
   logic        [7:0] mouth_lo, mouth_hi;

   // Only the source owning the current turn is looked at; the other one is ignored.
   always_comb begin
      mv_req    = 1'b0;
      mv_fmt_ok = 1'b0;
      nx        = $signed({1'b0, ball_x});
      ny        = $signed({1'b0, ball_y});
      if (state == OPP_TURN && new_en_mov) begin
         mv_req    = 1'b1;
         mv_fmt_ok = opp_ok;
         nx        = $signed({1'b0, ball_x}) + $signed({{7{opp_dx[1]}}, opp_dx});
         ny        = $signed({1'b0, ball_y}) + $signed({{7{opp_dy[1]}}, opp_dy});
      end else if (state == MY_TURN && my_move_valid) begin
         mv_req    = 1'b1;
         mv_fmt_ok = my_ok;
         nx        = $signed({1'b0, ball_x}) + $signed({{7{my_dx[1]}}, my_dx});
         ny        = $signed({1'b0, ball_y}) + $signed({{7{my_dy[1]}}, my_dy});
      end
      mouth_lo     = {1'b0, w_q[7:1]} - MOUTH_HALF;
      mouth_hi     = {1'b0, w_q[7:1]} + MOUTH_HALF;
      mv_legal     = mv_fmt_ok && (nx >= 9'sd0) && (nx <= $signed({1'b0, w_q}))
                     && (ny >= 9'sd0) && (ny <= $signed({1'b0, l_q}));
      in_mouth     = (nx >= $signed({1'b0, mouth_lo})) && (nx <= $signed({1'b0, mouth_hi}));
      // Red defends row 0, so reaching row 0 in the mouth is a blue goal.
      mv_goal_blue = mv_legal && in_mouth && (ny == 9'sd0);
      mv_goal_red  = mv_legal && in_mouth && (ny == $signed({1'b0, l_q}));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         colour_q      <= COL_NONE;
         w_q           <= 8'd0;
         l_q           <= 8'd0;
         ball_x        <= 8'd0;
         ball_y        <= 8'd0;
         move_accepted <= 1'b0;
         move_illegal  <= 1'b0;
         cfg_error     <= 1'b0;
         my_turn       <= 1'b0;
         goal_red      <= 1'b0;
         goal_blue     <= 1'b0;
         game_over     <= 1'b0;
      end else begin
         move_accepted <= 1'b0;
         move_illegal  <= 1'b0;
         unique case (state)
            IDLE: begin
               // A rejected configuration is sticky until reset.
               if (!cfg_error && width_valid && length_valid && color_valid) begin
                  if (dim_ok(width) && dim_ok(length)) begin
                     w_q      <= width;
                     l_q      <= length;
                     colour_q <= red ? COL_RED : (blue ? COL_BLUE : COL_NONE);
                     ball_x   <= {1'b0, width[7:1]};
                     ball_y   <= {1'b0, length[7:1]};
                     state    <= READY;
                  end else begin
                     cfg_error <= 1'b1;
                  end
               end
            end
            READY: begin
               if (opponent_game_start) begin
                  state <= OPP_TURN;
               end else if (colour_q == COL_RED) begin
                  state   <= MY_TURN;
                  my_turn <= 1'b1;
               end
            end
            OPP_TURN, MY_TURN: begin
               if (mv_req) begin
                  if (mv_legal) begin
                     ball_x        <= nx[7:0];
                     ball_y        <= ny[7:0];
                     move_accepted <= 1'b1;
                  end else begin
                     move_illegal <= 1'b1;
                  end
               end
               // The move is judged in the current turn; a goal overrides any turn change.
               if (mv_goal_red || mv_goal_blue) begin
                  goal_red  <= mv_goal_red;
                  goal_blue <= mv_goal_blue;
                  game_over <= 1'b1;
                  my_turn   <= 1'b0;
                  state     <= GAME_OVER;
               end else if (state == OPP_TURN && me_game_start) begin
                  state   <= MY_TURN;
                  my_turn <= 1'b1;
               end else if (state == MY_TURN && opponent_game_start) begin
                  state   <= OPP_TURN;
                  my_turn <= 1'b0;
               end
            end
            GAME_OVER: begin
               state <= GAME_OVER;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ball_tracker.sv
// tb_ball_tracker: directed scenarios plus randomized play against a
// behavioural model of the game rules.
module tb_ball_tracker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] width, length, RxD_data_Opponent;
   logic       width_valid, length_valid, red, blue, color_valid;
   logic       opponent_game_start, me_game_start, new_en_mov, my_move_valid;
   logic [2:0] my_move;
   logic [7:0] ball_x, ball_y;
   logic       move_accepted, move_illegal, cfg_error, my_turn, goal_red, goal_blue, game_over;

   ball_tracker dut (
      .clk                 (clk),
      .rst                 (rst),
      .width               (width),
      .width_valid         (width_valid),
      .length              (length),
      .length_valid        (length_valid),
      .red                 (red),
      .blue                (blue),
      .color_valid         (color_valid),
      .opponent_game_start (opponent_game_start),
      .me_game_start       (me_game_start),
      .new_en_mov          (new_en_mov),
      .RxD_data_Opponent   (RxD_data_Opponent),
      .my_move_valid       (my_move_valid),
      .my_move             (my_move),
      .ball_x              (ball_x),
      .ball_y              (ball_y),
      .move_accepted       (move_accepted),
      .move_illegal        (move_illegal),
      .cfg_error           (cfg_error),
      .my_turn             (my_turn),
      .goal_red            (goal_red),
      .goal_blue           (goal_blue),
      .game_over           (game_over)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model of the game rules.
   localparam int P_IDLE = 0, P_READY = 1, P_OPP = 2, P_MY = 3, P_OVER = 4;
   int m_phase = P_IDLE;
   int m_w = 0, m_l = 0, m_x = 0, m_y = 0;
   bit m_red = 0, m_cfg = 0, m_acc = 0, m_ill = 0, m_gr = 0, m_gb = 0;
   int dxt [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
   int dyt [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

   task automatic model_step();
      int  d, nx, ny;
      bit  has, ok, goal;
      m_acc = 0; m_ill = 0; goal = 0; has = 0; ok = 0; d = 0;
      if (rst) begin
         m_phase = P_IDLE; m_x = 0; m_y = 0; m_w = 0; m_l = 0;
         m_red = 0; m_cfg = 0; m_gr = 0; m_gb = 0;
         return;
      end
      case (m_phase)
         P_IDLE: if (!m_cfg && width_valid && length_valid && color_valid) begin
            if (width % 2 == 0 && length % 2 == 0 && width >= 4 && width <= 64
                && length >= 4 && length <= 64) begin
               m_w = width; m_l = length; m_red = red;
               m_x = m_w / 2; m_y = m_l / 2; m_phase = P_READY;
            end else m_cfg = 1;
         end
         P_READY: begin
            if (opponent_game_start) m_phase = P_OPP;
            else if (m_red) m_phase = P_MY;
         end
         P_OPP, P_MY: begin
            if (m_phase == P_OPP && new_en_mov) begin
               has = 1;
               ok  = (RxD_data_Opponent >= 8'h30) && (RxD_data_Opponent <= 8'h37);
               d   = ok ? int'(RxD_data_Opponent) - 48 : 0;
            end else if (m_phase == P_MY && my_move_valid) begin
               has = 1; ok = 1; d = int'(my_move);
            end
            if (has) begin
               nx = m_x + dxt[d];
               ny = m_y + dyt[d];
               if (ok && nx >= 0 && nx <= m_w && ny >= 0 && ny <= m_l) begin
                  m_acc = 1; m_x = nx; m_y = ny;
                  if ((ny == 0 || ny == m_l) && (nx - m_w / 2) >= -1 && (nx - m_w / 2) <= 1) begin
                     goal = 1;
                     if (ny == 0) m_gb = 1; else m_gr = 1;
                     m_phase = P_OVER;
                  end
               end else m_ill = 1;
            end
            if (!goal) begin
               if (m_phase == P_OPP && me_game_start) m_phase = P_MY;
               else if (m_phase == P_MY && opponent_game_start) m_phase = P_OPP;
            end
         end
         default: ;
      endcase
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      width = 0; length = 0; width_valid = 0; length_valid = 0;
      red = 0; blue = 0; color_valid = 0;
      opponent_game_start = 0; me_game_start = 0;
      new_en_mov = 0; RxD_data_Opponent = 0; my_move_valid = 0; my_move = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1; tick(); tick(); rst = 0;
   endtask

   task automatic configure(input logic [7:0] w, input logic [7:0] l, input logic r);
      width = w; length = l; red = r; blue = !r;
      width_valid = 1; length_valid = 1; color_valid = 1;
      tick();
      width_valid = 0; length_valid = 0; color_valid = 0;
   endtask

   task automatic my_mv(input logic [2:0] d);
      my_move = d; my_move_valid = 1; tick(); my_move_valid = 0;
   endtask

   task automatic opp_mv(input logic [7:0] b);
      RxD_data_Opponent = b; new_en_mov = 1; tick(); new_en_mov = 0;
   endtask

   task automatic pulse_start(input bit opp);
      if (opp) opponent_game_start = 1; else me_game_start = 1;
      tick();
      opponent_game_start = 0; me_game_start = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1; my_move_valid = 1; new_en_mov = 1; opponent_game_start = 1;
      width = 8; length = 10; width_valid = 1; length_valid = 1; color_valid = 1; red = 1;
      tick(); tick();
      checks++;
      if ({ball_x, ball_y, move_accepted, move_illegal, cfg_error, my_turn, goal_red, goal_blue,
           game_over} !== 23'd0)
         begin errors++; $display("FAIL reset_outputs: got x=%0d y=%0d acc=%b ill=%b cfg=%b my=%b gr=%b gb=%b go=%b want all 0",
            ball_x, ball_y, move_accepted, move_illegal, cfg_error, my_turn, goal_red, goal_blue, game_over); end
      rst = 0; clear_inputs();
   endtask

   task automatic test_config_good();
      do_reset();
      width = 8; length = 10; red = 1; width_valid = 1; length_valid = 1; color_valid = 0;
      tick(); clear_inputs();
      checks++;
      if ({ball_x, ball_y} !== 16'd0)
         begin errors++; $display("FAIL cfg_partial_valid: got (%0d,%0d) want (0,0)", ball_x, ball_y); end
      configure(8'd8, 8'd10, 1'b1);
      checks++;
      if ({ball_x, ball_y, cfg_error, my_turn} !== {8'd4, 8'd5, 1'b0, 1'b0})
         begin errors++; $display("FAIL cfg_ball_ready: got (%0d,%0d) cfg=%b my=%b want (4,5) 0 0",
            ball_x, ball_y, cfg_error, my_turn); end
      tick();
      checks++;
      if (my_turn !== 1'b1)
         begin errors++; $display("FAIL cfg_my_turn: got %b want 1", my_turn); end
      // Smallest and largest legal fields.
      do_reset(); configure(8'd4, 8'd64, 1'b0);
      checks++;
      if ({ball_x, ball_y, cfg_error} !== {8'd2, 8'd32, 1'b0})
         begin errors++; $display("FAIL cfg_min_max: got (%0d,%0d) cfg=%b want (2,32) 0", ball_x, ball_y, cfg_error); end
      do_reset(); configure(8'd64, 8'd4, 1'b1);
      checks++;
      if ({ball_x, ball_y, cfg_error} !== {8'd32, 8'd2, 1'b0})
         begin errors++; $display("FAIL cfg_max_min: got (%0d,%0d) cfg=%b want (32,2) 0", ball_x, ball_y, cfg_error); end
   endtask

   task automatic test_config_bad();
      logic [7:0] bw [6] = '{8'd7, 8'd8, 8'd2, 8'd66, 8'd8, 8'd8};
      logic [7:0] bl [6] = '{8'd10, 8'd11, 8'd10, 8'd10, 8'd2, 8'd66};
      for (int i = 0; i < 6; i++) begin
         do_reset();
         configure(bw[i], bl[i], 1'b1);
         checks++;
         if ({cfg_error, ball_x, ball_y} !== {1'b1, 16'd0})
            begin errors++; $display("FAIL cfg_reject_%0d: got cfg=%b (%0d,%0d) want 1 (0,0)",
               i, cfg_error, ball_x, ball_y); end
         tick();
         pulse_start(1'b1);
         my_mv(3'd2);
         opp_mv(8'h32);
         checks++;
         if ({ball_x, ball_y, move_accepted, move_illegal, cfg_error, my_turn, game_over}
             !== {16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0})
            begin errors++; $display("FAIL cfg_reject_ignore_%0d: got (%0d,%0d) acc=%b ill=%b cfg=%b my=%b want (0,0) 0 0 1 0",
               i, ball_x, ball_y, move_accepted, move_illegal, cfg_error, my_turn); end
      end
   endtask

   task automatic test_opp_move();
      do_reset();
      configure(8'd8, 8'd10, 1'b0);
      tick();
      checks++;
      if (my_turn !== 1'b0)
         begin errors++; $display("FAIL blue_ready_wait: got my=%b want 0", my_turn); end
      pulse_start(1'b1);
      opp_mv(8'h32);
      checks++;
      if ({ball_x, ball_y, move_accepted, move_illegal} !== {8'd5, 8'd5, 1'b1, 1'b0})
         begin errors++; $display("FAIL opp_east: got (%0d,%0d) acc=%b ill=%b want (5,5) 1 0",
            ball_x, ball_y, move_accepted, move_illegal); end
      tick();
      checks++;
      if ({move_accepted, move_illegal} !== 2'b00)
         begin errors++; $display("FAIL opp_pulse_width: got acc=%b ill=%b want 0 0", move_accepted, move_illegal); end
      opp_mv(8'h41);
      checks++;
      if ({ball_x, ball_y, move_accepted, move_illegal} !== {8'd5, 8'd5, 1'b0, 1'b1})
         begin errors++; $display("FAIL opp_bad_byte_41: got (%0d,%0d) acc=%b ill=%b want (5,5) 0 1",
            ball_x, ball_y, move_accepted, move_illegal); end
      opp_mv(8'h38);
      checks++;
      if ({move_accepted, move_illegal} !== 2'b01)
         begin errors++; $display("FAIL opp_bad_byte_38: got acc=%b ill=%b want 0 1", move_accepted, move_illegal); end
      opp_mv(8'h2F);
      checks++;
      if ({move_accepted, move_illegal} !== 2'b01)
         begin errors++; $display("FAIL opp_bad_byte_2f: got acc=%b ill=%b want 0 1", move_accepted, move_illegal); end
      my_mv(3'd2);
      checks++;
      if ({ball_x, move_accepted, move_illegal} !== {8'd5, 1'b0, 1'b0})
         begin errors++; $display("FAIL my_move_in_opp_turn: got x=%0d acc=%b ill=%b want 5 0 0",
            ball_x, move_accepted, move_illegal); end
      pulse_start(1'b0);
      checks++;
      if (my_turn !== 1'b1)
         begin errors++; $display("FAIL me_start: got my=%b want 1", my_turn); end
      opp_mv(8'h36);
      checks++;
      if ({ball_x, move_accepted, move_illegal} !== {8'd5, 1'b0, 1'b0})
         begin errors++; $display("FAIL opp_move_in_my_turn: got x=%0d acc=%b ill=%b want 5 0 0",
            ball_x, move_accepted, move_illegal); end
   endtask

   task automatic test_edges();
      do_reset(); configure(8'd8, 8'd10, 1'b1); tick();
      for (int i = 0; i < 4; i++) my_mv(3'd6);
      for (int i = 0; i < 2; i++) my_mv(3'd0);
      checks++;
      if ({ball_x, ball_y, move_accepted} !== {8'd0, 8'd3, 1'b1})
         begin errors++; $display("FAIL walk_to_0_3: got (%0d,%0d) acc=%b want (0,3) 1", ball_x, ball_y, move_accepted); end
      my_mv(3'd6);
      checks++;
      if ({ball_x, ball_y, move_accepted, move_illegal} !== {8'd0, 8'd3, 1'b0, 1'b1})
         begin errors++; $display("FAIL west_edge: got (%0d,%0d) acc=%b ill=%b want (0,3) 0 1",
            ball_x, ball_y, move_accepted, move_illegal); end
      for (int i = 0; i < 8; i++) my_mv(3'd2);
      my_mv(3'd2);
      checks++;
      if ({ball_x, ball_y, move_accepted, move_illegal} !== {8'd8, 8'd3, 1'b0, 1'b1})
         begin errors++; $display("FAIL east_edge: got (%0d,%0d) acc=%b ill=%b want (8,3) 0 1",
            ball_x, ball_y, move_accepted, move_illegal); end
      for (int i = 0; i < 3; i++) my_mv(3'd0);
      checks++;
      if ({ball_x, ball_y, move_accepted, goal_red, goal_blue, game_over} !== {8'd8, 8'd0, 1'b1, 3'b000})
         begin errors++; $display("FAIL corner_no_goal: got (%0d,%0d) acc=%b gr=%b gb=%b go=%b want (8,0) 1 0 0 0",
            ball_x, ball_y, move_accepted, goal_red, goal_blue, game_over); end
      my_mv(3'd0);
      checks++;
      if ({ball_y, move_illegal} !== {8'd0, 1'b1})
         begin errors++; $display("FAIL north_edge: got y=%0d ill=%b want 0 1", ball_y, move_illegal); end
   endtask

   task automatic test_goal();
      do_reset(); configure(8'd8, 8'd10, 1'b1); tick();
      for (int i = 0; i < 4; i++) my_mv(3'd0);
      checks++;
      if ({ball_x, ball_y, game_over} !== {8'd4, 8'd1, 1'b0})
         begin errors++; $display("FAIL pre_goal: got (%0d,%0d) go=%b want (4,1) 0", ball_x, ball_y, game_over); end
      my_mv(3'd0);
      checks++;
      if ({ball_x, ball_y, move_accepted, goal_blue, goal_red, game_over, my_turn}
          !== {8'd4, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0})
         begin errors++; $display("FAIL goal_blue: got (%0d,%0d) acc=%b gb=%b gr=%b go=%b my=%b want (4,0) 1 1 0 1 0",
            ball_x, ball_y, move_accepted, goal_blue, goal_red, game_over, my_turn); end
      my_mv(3'd4); pulse_start(1'b1); opp_mv(8'h34); pulse_start(1'b0); my_mv(3'd4);
      checks++;
      if ({ball_x, ball_y, move_accepted, move_illegal, game_over, my_turn} !== {8'd4, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0})
         begin errors++; $display("FAIL game_over_frozen: got (%0d,%0d) acc=%b ill=%b go=%b my=%b want (4,0) 0 0 1 0",
            ball_x, ball_y, move_accepted, move_illegal, game_over, my_turn); end
      do_reset(); configure(8'd8, 8'd10, 1'b0); tick(); pulse_start(1'b1);
      for (int i = 0; i < 4; i++) opp_mv(8'h34);
      opp_mv(8'h33);
      checks++;
      if ({ball_x, ball_y, move_accepted, goal_red, goal_blue, game_over} !== {8'd5, 8'd10, 1'b1, 1'b1, 1'b0, 1'b1})
         begin errors++; $display("FAIL goal_red: got (%0d,%0d) acc=%b gr=%b gb=%b go=%b want (5,10) 1 1 0 1",
            ball_x, ball_y, move_accepted, goal_red, goal_blue, game_over); end
   endtask

   task automatic test_corner();
      do_reset(); configure(8'd8, 8'd10, 1'b1); tick();
      for (int i = 0; i < 3; i++) my_mv(3'd7);
      my_mv(3'd0);
      my_mv(3'd7);
      checks++;
      if ({ball_x, ball_y, move_accepted, goal_blue, game_over} !== {8'd0, 8'd0, 1'b1, 1'b0, 1'b0})
         begin errors++; $display("FAIL corner_0_0: got (%0d,%0d) acc=%b gb=%b go=%b want (0,0) 1 0 0",
            ball_x, ball_y, move_accepted, goal_blue, game_over); end
      my_mv(3'd3);
      rst = 1; my_move = 3'd3; my_move_valid = 1; tick(); rst = 0; my_move_valid = 0;
      checks++;
      if ({ball_x, ball_y, move_accepted, move_illegal, cfg_error, my_turn, goal_red, goal_blue,
           game_over} !== 23'd0)
         begin errors++; $display("FAIL rst_mid_move: got x=%0d y=%0d acc=%b ill=%b my=%b want all 0",
            ball_x, ball_y, move_accepted, move_illegal, my_turn); end
      tick();
      checks++;
      if ({move_accepted, move_illegal, ball_x, ball_y} !== 18'd0)
         begin errors++; $display("FAIL rst_no_late_pulse: got acc=%b ill=%b (%0d,%0d) want 0 0 (0,0)",
            move_accepted, move_illegal, ball_x, ball_y); end
   endtask

   task automatic test_back_to_back();
      do_reset(); configure(8'd8, 8'd10, 1'b1); tick();
      my_move = 3'd2; my_move_valid = 1; opponent_game_start = 1; tick(); clear_inputs();
      checks++;
      if ({ball_x, ball_y, move_accepted, my_turn} !== {8'd5, 8'd5, 1'b1, 1'b0})
         begin errors++; $display("FAIL move_then_handover: got (%0d,%0d) acc=%b my=%b want (5,5) 1 0",
            ball_x, ball_y, move_accepted, my_turn); end
      RxD_data_Opponent = 8'h36; new_en_mov = 1; me_game_start = 1; tick(); clear_inputs();
      checks++;
      if ({ball_x, ball_y, move_accepted, my_turn} !== {8'd4, 8'd5, 1'b1, 1'b1})
         begin errors++; $display("FAIL opp_move_then_handover: got (%0d,%0d) acc=%b my=%b want (4,5) 1 1",
            ball_x, ball_y, move_accepted, my_turn); end
      my_mv(3'd4);
      checks++;
      if ({ball_y, move_accepted} !== {8'd6, 1'b1})
         begin errors++; $display("FAIL b2b_first: got y=%0d acc=%b want 6 1", ball_y, move_accepted); end
      my_mv(3'd4);
      checks++;
      if ({ball_y, move_accepted} !== {8'd7, 1'b1})
         begin errors++; $display("FAIL b2b_second: got y=%0d acc=%b want 7 1", ball_y, move_accepted); end
   endtask

   task automatic test_random();
      logic [22:0] got, want;
      for (int g = 0; g < 30; g++) begin
         do_reset();
         for (int c = 0; c < 150; c++) begin
            width  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255))
                   : 8'(2 * $urandom_range(2, ($urandom_range(0, 1) == 0) ? 4 : 32));
            length = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255))
                   : 8'(2 * $urandom_range(2, ($urandom_range(0, 1) == 0) ? 4 : 32));
            width_valid  = 1'($urandom_range(0, 1));
            length_valid = 1'($urandom_range(0, 1));
            color_valid  = 1'($urandom_range(0, 1));
            red  = 1'($urandom_range(0, 1));
            blue = !red;
            opponent_game_start = ($urandom_range(0, 9) == 0);
            me_game_start       = ($urandom_range(0, 9) == 0);
            new_en_mov          = ($urandom_range(0, 2) == 0);
            RxD_data_Opponent   = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255))
                                : 8'(8'h30 + $urandom_range(0, 7));
            my_move_valid = ($urandom_range(0, 2) == 0);
            my_move       = 3'($urandom_range(0, 7));
            rst           = ($urandom_range(0, 199) == 0);
            tick();
            got  = {ball_x, ball_y, move_accepted, move_illegal, cfg_error, my_turn, goal_red,
                    goal_blue, game_over};
            want = {m_x[7:0], m_y[7:0], m_acc, m_ill, m_cfg, (m_phase == P_MY), m_gr, m_gb,
                    (m_phase == P_OVER)};
            checks++;
            if (got !== want)
               begin errors++; $display("FAIL random_g%0d_c%0d: got %h want %h (x,y,acc,ill,cfg,my,gr,gb,go)",
                  g, c, got, want); end
         end
      end
      rst = 0; clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_config_good();
      test_config_bad();
      test_opp_move();
      test_edges();
      test_goal();
      test_corner();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
